// File: rtl/fle_frac_pkg.sv
// Shared types and configuration-word field offsets for the fracturable logic element.
// Offsets are functions of the LUT input count K.
package fle_frac_pkg;

    typedef enum logic [1:0] {
        FLE_LUT   = 2'd0,
        FLE_DUAL  = 2'd1,
        FLE_ARITH = 2'd2,
        FLE_RSVD  = 2'd3
    } fle_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } fle_state_e;

    function automatic int TT_LSB(input int k);
        TT_LSB = 0 * k;
    endfunction

    function automatic int MODE_LSB(input int k);
        MODE_LSB = 2 ** k;
    endfunction

    function automatic int REGEN_LSB(input int k);
        REGEN_LSB = 2 ** k + 2;
    endfunction

    function automatic int CFG_W(input int k);
        CFG_W = 2 ** k + 4;
    endfunction

endpackage

// File: rtl/fle_frac_lut.sv
// Combinational truth-table lookup: two (K-1)-input halves plus the full K-input result.
module fle_frac_lut #(
    parameter int K = 4
) (
    input  logic [2**K-1:0] tt,
    input  logic [K-1:0]    lut_in,
    output logic            lo,
    output logic            hi,
    output logic            full
);
    localparam int H = 2 ** (K - 1);

    logic [H-1:0] tt_lo;
    logic [H-1:0] tt_hi;

    assign tt_lo = tt[H-1:0];
    assign tt_hi = tt[2**K-1:H];
    assign lo    = tt_lo[lut_in[K-2:0]];
    assign hi    = tt_hi[lut_in[K-2:0]];
    assign full  = lut_in[K-1] ? hi : lo;

endmodule

// File: rtl/fle_frac_k.sv
// Fracturable K-input logic element with serial config chain, load tracking and output registers.
// Scan of the output registers is built only when FLE_FRAC_SCAN_EN is defined.
module fle_frac_k #(
    parameter int K     = 4,
    parameter int CFG_W = 2**K + 4
) (
    input  logic         fle_clk,
    input  logic         fle_reset_n,
    input  logic         config_enable,
    input  logic         ccff_head,
    output logic         ccff_tail,
    input  logic         Test_en,
    input  logic         fle_sc_in,
    output logic         fle_sc_out,
    input  logic [K-1:0] fle_in,
    input  logic         fle_cin,
    output logic         fle_cout,
    output logic [1:0]   fle_out,
    output logic         cfg_done
);
    import fle_frac_pkg::*;

    localparam int TT_W  = 2 ** K;
    localparam int TT_L  = TT_LSB(K);
    localparam int MD_L  = MODE_LSB(K);
    localparam int RE_L  = REGEN_LSB(K);
    localparam int CNT_W = $clog2(CFG_W + 1);

    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fle_state_e       state_q, state_d;
    logic [1:0]       ff_q, ff_d;

    logic [TT_W-1:0]  tt;
    fle_mode_e        mode;
    logic [1:0]       reg_en;
    logic             lo, hi, full;
    logic [1:0]       r;
    logic             cout_raw;

    assign tt     = cfg_q[TT_L +: TT_W];
    assign mode   = fle_mode_e'(cfg_q[MD_L +: 2]);
    assign reg_en = cfg_q[RE_L +: 2];

    fle_frac_lut #(.K(K)) u_lut (
        .tt     (tt),
        .lut_in (fle_in),
        .lo     (lo),
        .hi     (hi),
        .full   (full)
    );

    always_comb begin
        cfg_d = cfg_q;
        if (config_enable) cfg_d = {cfg_q[CFG_W-2:0], ccff_head};
    end

    // The entry shift out of IDLE/READY is already the first counted bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (config_enable) begin
                    state_d = ST_LOAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (config_enable) begin
                    if (cnt_q != CNT_W'(CFG_W)) cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = (cnt_q == CNT_W'(CFG_W)) ? ST_READY : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // lo acts as propagate and hi as generate in arithmetic mode.
    always_comb begin
        r        = {1'b0, full};
        cout_raw = 1'b0;
        case (mode)
            FLE_DUAL:  r = {hi, lo};
            FLE_ARITH: begin
                r        = {full, lo ^ fle_cin};
                cout_raw = lo ? fle_cin : hi;
            end
            default:   r = {1'b0, full};
        endcase
    end

    always_comb begin
        ff_d = ff_q;
        if (!config_enable) begin
`ifdef FLE_FRAC_SCAN_EN
            if (Test_en) ff_d = {ff_q[0], fle_sc_in};
            else         ff_d = r;
`else
            ff_d = r;
`endif
        end
    end

    always_ff @(posedge fle_clk or negedge fle_reset_n) begin
        if (!fle_reset_n) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            ff_q    <= '0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ff_q    <= ff_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) fle_out[i] = reg_en[i] ? ff_q[i] : r[i];
        if (config_enable) fle_out = 2'b00;
    end

    assign fle_cout  = config_enable ? 1'b0 : cout_raw;
    assign ccff_tail = cfg_q[CFG_W-1];
    assign cfg_done  = (state_q == ST_READY);

`ifdef FLE_FRAC_SCAN_EN
    assign fle_sc_out = config_enable ? 1'b0 : ff_q[1];
`else
    logic unused_scan;
    assign unused_scan = Test_en ^ fle_sc_in;
    assign fle_sc_out  = 1'b0;
`endif

endmodule

// File: doc/fle_frac_k.md
# fle_frac_k

Parametrised fracturable logic element with an on-block configuration chain, a per-output register and a carry path. It is the successor to the fixed 4-input logic element. LUT size is parametric. The LUT can be used whole or split into two halves, or used as a one-bit adder. Configuration is loaded serially through the ccff chain, and the block tracks load completion itself. Instances sit inside the CLB and are chained through `ccff`, scan and carry.

## Interface
Parameters:
- `K`, default 4: LUT input count, legal range 3..6.
- `CFG_W`, default `2**K+4`: configuration word width. Derived; must not be overridden.

Ports (name, direction, width, meaning):
- `fle_clk`, in, 1: single clock, used for both configuration shifting and user logic.
- `fle_reset_n`, in, 1: reset, asynchronous, active-low.
- `config_enable`, in, 1: when high, the configuration chain shifts each cycle.
- `ccff_head`, in, 1: serial configuration input.
- `ccff_tail`, out, 1: serial configuration output; equals `cfg[CFG_W-1]`.
- `Test_en`, in, 1: selects scan operation of the output registers.
- `fle_sc_in`, in, 1: scan input.
- `fle_sc_out`, out, 1: scan output.
- `fle_in`, in, K: LUT inputs.
- `fle_cin`, in, 1: carry input.
- `fle_cout`, out, 1: carry output.
- `fle_out`, out, 2: logic outputs.
- `cfg_done`, out, 1: configuration loaded and active.

## Operation
Configuration word layout:
- `cfg[2**K-1:0]`: truth table.
- `cfg[2**K+1:2**K]`: mode.
- `cfg[2**K+3:2**K+2]`: `reg_en[1:0]`.

Configuration loading:
- Shift rule: `cfg <= {cfg[CFG_W-2:0], ccff_head}`. The first bit shifted in ends at the MSB after `CFG_W` shifts.

LUT halves:
- `lo` = truth-table bit at index `fle_in[K-2:0]`.
- `hi` = truth-table bit at index `2**(K-1) + fle_in[K-2:0]`.
- `full` = `fle_in[K-1] ? hi : lo`.

Modes:
- Mode 0, K-LUT: `r0 = full`, `r1 = 0`, `fle_cout = 0`.
- Mode 1, dual (K-1)-LUT: `r0 = lo`, `r1 = hi`, `fle_cout = 0`.
- Mode 2, arithmetic: `r0 = lo ^ fle_cin`, `r1 = full`, `fle_cout = lo ? fle_cin : hi` (`lo` is propagate, `hi` is generate).
- Mode 3: reserved; behaves exactly as mode 0.

Outputs:
- `fle_out[i] = reg_en[i] ? ff[i] : r[i]`.
- While `config_enable` is high, `fle_out`, `fle_cout` and `fle_sc_out` are forced to 0, and `ff` holds its value.

Load-tracking FSM:
- States: IDLE, LOAD, READY.
- IDLE to LOAD: on `config_enable` = 1. `cnt` is cleared to 0 in the entry cycle, and that cycle's shift counts as 1.
- LOAD: `cnt` increments once per shift and saturates at `CFG_W`.
- LOAD to READY: on `config_enable` = 0 with `cnt == CFG_W`.
- LOAD to IDLE: on `config_enable` = 0 with `cnt < CFG_W`. This is a short load; `cfg` keeps the partially shifted contents and `cfg_done` stays 0.
- READY to LOAD: on `config_enable` = 1, restarting the count.
- `cfg_done` = 1 only in READY.

Reset (`fle_reset_n` low):
- `cfg`, `cnt` and `ff` clear to 0; the FSM goes to IDLE.
- All outputs are 0: `fle_out`, `fle_cout`, `fle_sc_out`, `ccff_tail`, `cfg_done`.
- Reset asserted mid-load aborts the load immediately.

## Timing
- Combinational outputs (`reg_en[i]` = 0) and `fle_cout` have zero cycle latency from `fle_in` / `fle_cin`.
- Registered outputs: `ff[i] <= r[i]` on each `fle_clk` edge when `config_enable` = 0 and `Test_en` = 0; visible 1 cycle later.
- `ccff_tail` is registered: 1 cycle per bit, so the chain delay is `CFG_W` cycles per block.
- `cfg_done` rises in the cycle after `config_enable` falls, provided `cnt == CFG_W`.
- If `config_enable` and `Test_en` are both high, configuration wins: `ff` holds.

## Configuration
`FLE_FRAC_SCAN_EN` controls scan:
- Defined: when `Test_en` = 1 and `config_enable` = 0, `ff[0] <= fle_sc_in` and `ff[1] <= ff[0]`; `fle_sc_out = ff[1]`.
- Not defined: `Test_en` and `fle_sc_in` are ignored, `fle_sc_out` is tied to 0, and `ff` always captures `r`.

## Structure
- Package `fle_frac_pkg` holds:
  - the mode enum (`FLE_LUT`, `FLE_DUAL`, `FLE_ARITH`, `FLE_RSVD`);
  - FSM state enum;
  - field offset functions of `K` (`TT_LSB`, `MODE_LSB`, `REGEN_LSB`, `CFG_W`).
- One sub-module: `fle_frac_lut`, the combinational truth-table lookup producing `lo`, `hi` and `full`. The FSM, chain, registers and mode muxing live in the top.

## Test plan
All scenarios use K = 4, so `CFG_W` = 20.

1. Reset, then idle -> every output 0 and `cfg_done` = 0. Shift in 20 bits (`reg_en` = 00, mode 0, truth table 16'h8000) -> `cfg_done` = 1 one cycle after `config_enable` falls. Then `fle_in` = 4'hF -> `fle_out` = 2'b01; `fle_in` = 4'hE -> 2'b00.
2. Arithmetic mode, truth table lo = XOR(in0,in1) / hi = AND(in0,in1), i.e. 16'h8866 -> `fle_in` = 4'b0011, `fle_cin` = 1 gives `fle_out[0]` = 1 and `fle_cout` = 1; `fle_in` = 4'b0001, `fle_cin` = 1 gives `fle_out[0]` = 0 and `fle_cout` = 1.
3. Dual mode, `reg_en` = 11, truth table 16'hFF00 -> `fle_in[2:0]` = any value gives `fle_out` = 2'b10, appearing exactly 1 cycle after `config_enable` drops.
4. Short load of 12 bits -> `cfg_done` stays 0. A following full 20-bit load -> `cfg_done` = 1. `ccff_tail` reproduces the input stream delayed by 20 cycles.
5. `fle_reset_n` pulsed low at bit 10 of a load -> outputs go to 0 immediately and the FSM is in IDLE. With `FLE_FRAC_SCAN_EN` defined: `Test_en` = 1 and `fle_sc_in` = 1,0 -> `fle_sc_out` = 1 two cycles after the first bit.
